// File: rtl/sqrt_iter_if.sv
// rtl/sqrt_iter_if.sv - request/result bundle for the iterative square root
interface sqrt_iter_if #(
  parameter int WIDTH = 8
);
  localparam int N = WIDTH / 2;

  logic           start;
  logic [WIDTH-1:0] rad;
  logic           busy;
  logic           valid;
  logic [N-1:0]   root;
  logic [N:0]     rem;

  modport master (output start, rad, input busy, valid, root, rem);
  modport slave  (input start, rad, output busy, valid, root, rem);
endinterface

// File: rtl/sqrt_iter.sv
// rtl/sqrt_iter.sv - digit-by-digit unsigned integer square root, one root bit per cycle
module sqrt_iter #(
  parameter int WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  sqrt_iter_if.slave bus
);
  localparam int N  = WIDTH / 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] x_q;
  logic [N-1:0]     q_q;
  logic [N-1:0]     ac_q;
  logic [CW-1:0]    i_q;
  logic             busy_q;
  logic             valid_q;
  logic [N-1:0]     root_q;
  logic [N:0]       rem_q;

  logic [N+1:0]     ac_shift_d;
  logic [N+1:0]     t_d;
  logic             t_neg_d;
  logic [N:0]       ac_d;
  logic [N-1:0]     q_d;

  // Partial remainder never exceeds 2*q, so N stored bits suffice; the
  // top bit of the trial subtraction doubles as its sign.
  always_comb begin
    ac_shift_d = {ac_q, x_q[WIDTH-1:WIDTH-2]};
    t_d        = ac_shift_d - {q_q, 2'b01};
    t_neg_d    = t_d[N+1];
    ac_d       = t_neg_d ? ac_shift_d[N:0] : t_d[N:0];
    q_d        = {q_q[N-2:0], ~t_neg_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      q_q     <= '0;
      ac_q    <= '0;
      i_q     <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      root_q  <= '0;
      rem_q   <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            x_q     <= bus.rad;
            q_q     <= '0;
            ac_q    <= '0;
            i_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          x_q  <= {x_q[WIDTH-3:0], 2'b00};
          ac_q <= ac_d[N-1:0];
          q_q  <= q_d;
          i_q  <= i_q + 1'b1;
          if (i_q == LAST) begin
            root_q  <= q_d;
            rem_q   <= ac_d;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.valid = valid_q;
  assign bus.root  = root_q;
  assign bus.rem   = rem_q;
endmodule

// File: tb/tb_sqrt_iter.sv
// tb/tb_sqrt_iter.sv - scoreboard bench for sqrt_iter at WIDTH 8 and 16
module tb_sqrt_iter;
  typedef struct {
    int rad;
    int root;
    int rem;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst8;
  logic rst16;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   n_valid8 = 0;
  int   n_valid16 = 0;
  exp_t sb8[$];
  exp_t sb16[$];
  exp_t e8;
  exp_t e16;

  sqrt_iter_if #(.WIDTH(8))  bus8 ();
  sqrt_iter_if #(.WIDTH(16)) bus16 ();

  sqrt_iter #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst8),  .bus(bus8.slave));
  sqrt_iter #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst16), .bus(bus16.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int rad, input int n);
    exp_t e;
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= rad) r++;
    e.rad  = rad;
    e.root = r;
    e.rem  = rad - r * r;
    e.cyc  = cyc + 1 + n;
    return e;
  endfunction

  // Drive from just after a rising edge; the next edge samples start.
  task automatic issue8(input int rad, input bit push);
    bus8.start = 1'b1;
    bus8.rad   = rad[7:0];
    if (push) sb8.push_back(model(rad, 4));
    @(posedge clk); #1;
    bus8.start = 1'b0;
  endtask

  task automatic issue16(input int rad);
    bus16.start = 1'b1;
    bus16.rad   = rad[15:0];
    sb16.push_back(model(rad, 8));
    @(posedge clk); #1;
    bus16.start = 1'b0;
  endtask

  task automatic wait_valid8(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus8.valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!seen) check_eq("timeout8", 0, 1);
  endtask

  task automatic wait_valid16(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (bus16.valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!seen) check_eq("timeout16", 0, 1);
  endtask

  always @(negedge clk) begin
    if (bus8.valid === 1'b1) begin
      n_valid8++;
      if (sb8.size() == 0) begin
        check_eq("unexpected_valid8", 1, 0);
      end else begin
        e8 = sb8.pop_front();
        check_eq("root8", bus8.root, e8.root);
        check_eq("rem8", bus8.rem, e8.rem);
        check_eq("latency8", cyc, e8.cyc);
        check_eq("identity8", bus8.root * bus8.root + bus8.rem, e8.rad);
        check_eq("rem_bound8", (bus8.rem <= 2 * bus8.root), 1);
      end
    end
  end

  always @(negedge clk) begin
    if (bus16.valid === 1'b1) begin
      n_valid16++;
      if (sb16.size() == 0) begin
        check_eq("unexpected_valid16", 1, 0);
      end else begin
        e16 = sb16.pop_front();
        check_eq("root16", bus16.root, e16.root);
        check_eq("rem16", bus16.rem, e16.rem);
        check_eq("latency16", cyc, e16.cyc);
      end
    end
  end

  initial begin
    bit seen;
    int base;
    rst8 = 1'b1;
    rst16 = 1'b1;
    bus8.start = 1'b0;
    bus8.rad = '0;
    bus16.start = 1'b0;
    bus16.rad = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", bus8.busy, 0);
    check_eq("rst_valid", bus8.valid, 0);
    check_eq("rst_root", bus8.root, 0);
    check_eq("rst_rem", bus8.rem, 0);
    check_eq("rst_busy16", bus16.busy, 0);
    rst8 = 1'b0;
    rst16 = 1'b0;
    @(posedge clk); #1;

    issue8(0, 1'b1);
    check_eq("busy_after_accept", bus8.busy, 1);
    wait_valid8(seen);
    check_eq("busy_on_valid", bus8.busy, 0);
    @(posedge clk); #1;
    check_eq("valid_one_cycle", bus8.valid, 0);

    issue8(255, 1'b1);
    wait_valid8(seen);
    check_eq("root_255", bus8.root, 15);
    check_eq("rem_255", bus8.rem, 30);
    issue8(144, 1'b1);
    wait_valid8(seen);
    check_eq("root_144", bus8.root, 12);
    check_eq("rem_144", bus8.rem, 0);
    issue8(143, 1'b1);
    wait_valid8(seen);
    check_eq("root_143", bus8.root, 11);
    check_eq("rem_143", bus8.rem, 22);
    @(posedge clk); #1;

    // Back-to-back sweep: each request issued on the previous valid cycle.
    base = n_valid8;
    issue8(0, 1'b1);
    for (int r = 1; r < 256; r++) begin
      wait_valid8(seen);
      issue8(r, 1'b1);
    end
    wait_valid8(seen);
    @(posedge clk); #1;
    check_eq("sweep_count", n_valid8 - base, 256);

    base = n_valid8;
    issue8(100, 1'b1);
    @(posedge clk); #1;
    bus8.start = 1'b1;
    bus8.rad = 8'd7;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    wait_valid8(seen);
    check_eq("busy_prot_root", bus8.root, 10);
    check_eq("busy_prot_rem", bus8.rem, 0);
    repeat (10) @(posedge clk);
    #1;
    check_eq("busy_prot_count", n_valid8 - base, 1);
    check_eq("hold_root", bus8.root, 10);
    check_eq("hold_rem", bus8.rem, 0);

    base = n_valid8;
    issue8(200, 1'b0);
    @(posedge clk); #1;
    rst8 = 1'b1;
    @(posedge clk); #1;
    rst8 = 1'b0;
    check_eq("abort_busy", bus8.busy, 0);
    check_eq("abort_root", bus8.root, 0);
    check_eq("abort_rem", bus8.rem, 0);
    repeat (8) @(posedge clk);
    #1;
    check_eq("abort_no_valid", n_valid8 - base, 0);
    issue8(200, 1'b1);
    wait_valid8(seen);
    check_eq("root_200", bus8.root, 14);
    check_eq("rem_200", bus8.rem, 4);

    issue16(65535);
    wait_valid16(seen);
    check_eq("root_65535", bus16.root, 255);
    check_eq("rem_65535", bus16.rem, 510);
    issue16(40000);
    wait_valid16(seen);
    check_eq("root_40000", bus16.root, 200);
    check_eq("rem_40000", bus16.rem, 0);
    for (int k = 0; k < 6; k++) begin
      issue16($urandom_range(65535));
      wait_valid16(seen);
    end
    repeat (3) @(posedge clk);
    #1;
    check_eq("sb8_drained", sb8.size(), 0);
    check_eq("sb16_drained", sb16.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
